i2c_slave_regs: RTL and testbench

Synthesizable I2C target (slave) with a byte-wide register file, addressed by an index pointer. It is the other end of the bus from the team's i2c_master bench model. It answers that model's transaction formats:
- Write: START, {addr,W}, index, data..., STOP.
- Read: START, {addr,W}, index, repeated START, {addr,R}, data..., NACK, STOP.

SCL/SDA are oversampled on the system clock. A host-side port exposes register contents and write events to the chip.

---
 rtl/i2c_slave_regs.sv | 244 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// I2C target with a DEPTH x 8 register file addressed by an auto-incrementing index pointer.
// Build option: define I2C_IDX_NACK_EN to NACK index bytes >= DEPTH instead of wrapping them.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | bus free or not addressed; SDA released, SCL edges ignored
// S_ADDR      | shifting in {addr,R/W}
// S_ADDR_ACK  | driving ACK for a matching address
// S_INDEX     | shifting in the register index
// S_INDEX_ACK | driving ACK for the index byte
// S_WRITE     | shifting in a data byte for registers[pointer]
// S_WRITE_ACK | driving ACK for a committed data byte
// S_READ      | shifting out registers[pointer], MSB first
// S_READ_ACK  | sampling the master's ACK/NACK
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SCL,
    inout  wire                      SDA,
    input  logic [$clog2(DEPTH)-1:0] HOST_ADDR,
    output logic [7:0]               HOST_RDATA,
    output logic                     WR_STROBE,
    output logic [7:0]               WR_INDEX,
    output logic [7:0]               WR_DATA,
    output logic                     BUSY
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_INDEX, S_INDEX_ACK,
        S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             bit_cnt, bit_cnt_nxt;
    logic [7:0]             shreg, shreg_nxt;
    logic                   byte_rdy, byte_rdy_nxt;
    logic                   sda_oe, sda_oe_nxt;
    logic [AW-1:0]          ptr, ptr_nxt;
    logic                   rw, rw_nxt;
    logic                   ack_ok, ack_ok_nxt;
    logic                   wr_strobe_nxt;
    logic [7:0]             wr_index_nxt, wr_data_nxt;
    logic                   reg_we;
    logic [7:0]             rd_byte;
    logic [7:0]             regs [DEPTH];

    // Bus idles high, so synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rd_byte   = regs[ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd7;
            shreg     <= '0;
            byte_rdy  <= 1'b0;
            sda_oe    <= 1'b0;
            ptr       <= '0;
            rw        <= 1'b0;
            ack_ok    <= 1'b0;
            WR_STROBE <= 1'b0;
            WR_INDEX  <= '0;
            WR_DATA   <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            byte_rdy  <= byte_rdy_nxt;
            sda_oe    <= sda_oe_nxt;
            ptr       <= ptr_nxt;
            rw        <= rw_nxt;
            ack_ok    <= ack_ok_nxt;
            WR_STROBE <= wr_strobe_nxt;
            WR_INDEX  <= wr_index_nxt;
            WR_DATA   <= wr_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        byte_rdy_nxt  = byte_rdy;
        sda_oe_nxt    = sda_oe;
        ptr_nxt       = ptr;
        rw_nxt        = rw;
        ack_ok_nxt    = ack_ok;
        wr_strobe_nxt = 1'b0;
        wr_index_nxt  = WR_INDEX;
        wr_data_nxt   = WR_DATA;
        reg_we        = 1'b0;
        if (start_det) begin
            state_nxt    = S_ADDR;
            bit_cnt_nxt  = 3'd7;
            byte_rdy_nxt = 1'b0;
            sda_oe_nxt   = 1'b0;
            ack_ok_nxt   = 1'b0;
        end else if (stop_det) begin
            state_nxt    = S_IDLE;
            byte_rdy_nxt = 1'b0;
            sda_oe_nxt   = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_INDEX, S_WRITE: begin
                    // Byte completes on the 8th rise; it is acted on at the following fall.
                    if (scl_rise) begin
                        shreg_nxt = {shreg[6:0], sda_s};
                        if (bit_cnt == 3'd0) byte_rdy_nxt = 1'b1;
                        else                 bit_cnt_nxt  = bit_cnt - 3'd1;
                    end else if (scl_fall && byte_rdy) begin
                        byte_rdy_nxt = 1'b0;
                        bit_cnt_nxt  = 3'd7;
                        if (state == S_ADDR) begin
                            if (shreg[7:1] == SLAVE_ADDR) begin
                                rw_nxt     = shreg[0];
                                sda_oe_nxt = 1'b1;
                                state_nxt  = S_ADDR_ACK;
                            end else begin
                                state_nxt  = S_IDLE;
                            end
                        end else if (state == S_INDEX) begin
`ifdef I2C_IDX_NACK_EN
                            if ({1'b0, shreg} >= 9'(DEPTH)) begin
                                sda_oe_nxt = 1'b0;
                                state_nxt  = S_IDLE;
                            end else
`endif
                            begin
                                ptr_nxt    = shreg[AW-1:0];
                                sda_oe_nxt = 1'b1;
                                state_nxt  = S_INDEX_ACK;
                            end
                        end else begin
                            reg_we        = 1'b1;
                            wr_strobe_nxt = 1'b1;
                            wr_index_nxt  = 8'(ptr);
                            wr_data_nxt   = shreg;
                            sda_oe_nxt    = 1'b1;
                            state_nxt     = S_WRITE_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            shreg_nxt  = rd_byte;
                            sda_oe_nxt = ~rd_byte[7];
                            state_nxt  = S_READ;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = S_INDEX;
                        end
                    end
                end
                S_INDEX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = S_WRITE;
                    end
                end
                S_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        ptr_nxt    = ptr + AW'(1);
                        state_nxt  = S_WRITE;
                    end
                end
                S_READ: begin
                    if (scl_rise) begin
                        if (bit_cnt == 3'd0) byte_rdy_nxt = 1'b1;
                        else                 bit_cnt_nxt  = bit_cnt - 3'd1;
                    end else if (scl_fall) begin
                        if (byte_rdy) begin
                            byte_rdy_nxt = 1'b0;
                            bit_cnt_nxt  = 3'd7;
                            sda_oe_nxt   = 1'b0;
                            state_nxt    = S_READ_ACK;
                        end else begin
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            sda_oe_nxt = ~shreg[6];
                        end
                    end
                end
                S_READ_ACK: begin
                    // Pointer advances on the ACK rise; the next byte loads at the fall.
                    if (scl_rise) begin
                        ptr_nxt = ptr + AW'(1);
                        if (sda_s) state_nxt  = S_IDLE;
                        else       ack_ok_nxt = 1'b1;
                    end else if (scl_fall && ack_ok) begin
                        ack_ok_nxt = 1'b0;
                        shreg_nxt  = rd_byte;
                        sda_oe_nxt = ~rd_byte[7];
                        state_nxt  = S_READ;
                    end
                end
                default: begin
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[ptr] <= shreg;
        end
    end

    // Reset gates the driver directly so SDA lets go without waiting for a flop.
    assign SDA        = (sda_oe && !RST) ? 1'b0 : 1'bz;
    assign HOST_RDATA = regs[HOST_ADDR];
    assign BUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Scoreboard bench for i2c_slave_regs: stimulus queues expectations, a monitor pops and compares.
module tb_i2c_slave_regs;
    localparam time TCLK = 10ns;
    localparam time Q    = 80ns;

    typedef struct {
        string       nm;
        logic [15:0] v;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        m_sda_low;
    logic [3:0]  host_addr;
    logic [7:0]  host_rdata;
    logic        wr_strobe;
    logic [7:0]  wr_index, wr_data;
    logic        busy;
    wire         sda_bus;

    item_t       exp_q[$];
    logic [15:0] act_q[$];
    logic [15:0] exp_wr[$];
    int          total = 0;
    int          bad   = 0;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #(TCLK/2) clk = ~clk;

    i2c_slave_regs #(.SLAVE_ADDR(7'h50), .DEPTH(16), .SYNC_STAGES(2)) dut (
        .CLK(clk), .RST(rst), .SCL(scl), .SDA(sda_bus),
        .HOST_ADDR(host_addr), .HOST_RDATA(host_rdata),
        .WR_STROBE(wr_strobe), .WR_INDEX(wr_index), .WR_DATA(wr_data), .BUSY(busy)
    );

    // Monitor: compares bus/host observations and every write strobe against queued expectations.
    always @(negedge clk) begin
        item_t       e;
        logic [15:0] a, w;
        while (act_q.size() > 0) begin
            a = act_q.pop_front();
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_obs got=%h want=<none>", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e.v) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", e.nm, a, e.v);
                end
            end
        end
        if (wr_strobe) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_strobe_unexpected got idx=%h data=%h want=<none>", wr_index, wr_data);
            end else begin
                w = exp_wr.pop_front();
                if ({wr_index, wr_data} !== w) begin
                    bad++;
                    $display("FAIL wr_strobe got idx=%h data=%h want idx=%h data=%h",
                             wr_index, wr_data, w[15:8], w[7:0]);
                end
            end
        end
    end

    task automatic exp_push(input string nm, input logic [15:0] v);
        item_t it;
        it.nm = nm;
        it.v  = v;
        exp_q.push_back(it);
    endtask

    task automatic act_push(input logic [15:0] v);
        act_q.push_back(v);
    endtask

    task automatic host_chk(input string nm, input logic [3:0] a, input logic [7:0] e);
        host_addr = a;
        #1;
        exp_push(nm, 16'(e));
        act_push(16'(host_rdata));
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b1; #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b0; #Q;
    endtask

    task automatic wr_bit(input logic b);
        m_sda_low = ~b; #Q;
        scl = 1'b1;     #(2*Q);
        scl = 1'b0;     #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(b[i]);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        ack = sda_bus;    #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl = 1'b1;
            #Q; b[i] = sda_bus;
            #Q; scl = 1'b0;
            #Q;
        end
        m_sda_low = ~nack; #Q;
        scl = 1'b1;        #(2*Q);
        scl = 1'b0;        #Q;
        m_sda_low = 1'b0;
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [7:0] idx, input int n,
                             input logic [7:0] d0, input logic [7:0] d1);
        logic ack;
        i2c_start();
        act_push(16'(busy));
        wr_byte({a, 1'b0}, ack); act_push(16'(ack));
        wr_byte(idx, ack);       act_push(16'(ack));
        for (int i = 0; i < n; i++) begin
            wr_byte((i == 0) ? d0 : d1, ack);
            act_push(16'(ack));
        end
        i2c_stop();
        repeat (4) @(posedge clk);
        #1 act_push(16'(busy));
    endtask

    task automatic bus_read(input logic [6:0] a, input logic [7:0] idx, input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        act_push(16'(busy));
        wr_byte({a, 1'b0}, ack); act_push(16'(ack));
        wr_byte(idx, ack);       act_push(16'(ack));
        i2c_start();
        wr_byte({a, 1'b1}, ack); act_push(16'(ack));
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, b);
            act_push(16'(b));
        end
        i2c_stop();
        repeat (4) @(posedge clk);
        #1 act_push(16'(busy));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0; host_addr = '0;
        repeat (5) @(posedge clk);
        #1;
        exp_push("rst_busy", 16'h0);     act_push(16'(busy));
        exp_push("rst_sda", 16'h1);      act_push(16'(sda_bus));
        exp_push("rst_wr_index", 16'h0); act_push(16'(wr_index));
        exp_push("rst_wr_data", 16'h0);  act_push(16'(wr_data));
        host_chk("rst_reg0", 4'd0, 8'h00);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Two-byte write at index 3
        exp_push("w1_busy_start", 16'h1);
        exp_push("w1_ack_addr", 16'h0);
        exp_push("w1_ack_idx", 16'h0);
        exp_push("w1_ack_d0", 16'h0);
        exp_push("w1_ack_d1", 16'h0);
        exp_push("w1_busy_stop", 16'h0);
        exp_wr.push_back({8'h03, 8'hAA});
        exp_wr.push_back({8'h04, 8'h55});
        bus_write(7'h50, 8'h03, 2, 8'hAA, 8'h55);
        host_chk("w1_reg3", 4'd3, 8'hAA);
        host_chk("w1_reg4", 4'd4, 8'h55);

        // Read back the same two bytes
        exp_push("r1_busy_start", 16'h1);
        exp_push("r1_ack_addr", 16'h0);
        exp_push("r1_ack_idx", 16'h0);
        exp_push("r1_ack_raddr", 16'h0);
        exp_push("r1_byte0", 16'h00AA);
        exp_push("r1_byte1", 16'h0055);
        exp_push("r1_busy_stop", 16'h0);
        bus_read(7'h50, 8'h03, 2);
        host_chk("r1_host4", 4'd4, 8'h55);

        // Wrong address: nothing ACKed, nothing written
        exp_push("bad_busy_start", 16'h1);
        exp_push("bad_ack_addr", 16'h1);
        exp_push("bad_ack_idx", 16'h1);
        exp_push("bad_ack_d0", 16'h1);
        exp_push("bad_busy_stop", 16'h0);
        bus_write(7'h51, 8'h03, 1, 8'h99, 8'h00);
        host_chk("bad_reg3", 4'd3, 8'hAA);

        // Pointer wrap 15 -> 0
        exp_push("wrap_busy_start", 16'h1);
        exp_push("wrap_ack_addr", 16'h0);
        exp_push("wrap_ack_idx", 16'h0);
        exp_push("wrap_ack_d0", 16'h0);
        exp_push("wrap_ack_d1", 16'h0);
        exp_push("wrap_busy_stop", 16'h0);
        exp_wr.push_back({8'h0F, 8'h11});
        exp_wr.push_back({8'h00, 8'h22});
        bus_write(7'h50, 8'h0F, 2, 8'h11, 8'h22);
        host_chk("wrap_reg15", 4'd15, 8'h11);
        host_chk("wrap_reg0", 4'd0, 8'h22);

        exp_push("rwrap_busy_start", 16'h1);
        exp_push("rwrap_ack_addr", 16'h0);
        exp_push("rwrap_ack_idx", 16'h0);
        exp_push("rwrap_ack_raddr", 16'h0);
        exp_push("rwrap_byte0", 16'h0011);
        exp_push("rwrap_byte1", 16'h0022);
        exp_push("rwrap_busy_stop", 16'h0);
        bus_read(7'h50, 8'h0F, 2);

        // Reset after the 4th data bit of a write
        exp_push("mid_ack_addr", 16'h0);
        exp_push("mid_ack_idx", 16'h0);
        i2c_start();
        wr_byte({7'h50, 1'b0}, ack); act_push(16'(ack));
        wr_byte(8'h02, ack);         act_push(16'(ack));
        for (int i = 7; i >= 4; i--) wr_bit(i[0] ? 1'b0 : 1'b1);
        m_sda_low = 1'b0;
        rst = 1'b1;
        #1;
        exp_push("mid_rst_sda", 16'h1);  act_push(16'(sda_bus));
        exp_push("mid_rst_busy", 16'h0); act_push(16'(busy));
        repeat (3) @(posedge clk);
        for (int i = 0; i < 16; i++) host_chk("mid_rst_reg", 4'(i), 8'h00);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        i2c_stop();
        repeat (4) @(posedge clk);
        exp_push("post_busy_start", 16'h1);
        exp_push("post_ack_addr", 16'h0);
        exp_push("post_ack_idx", 16'h0);
        exp_push("post_ack_d0", 16'h0);
        exp_push("post_busy_stop", 16'h0);
        exp_wr.push_back({8'h01, 8'h77});
        bus_write(7'h50, 8'h01, 1, 8'h77, 8'h00);
        host_chk("post_reg1", 4'd1, 8'h77);

        // Out-of-range index
        exp_push("oor_busy_start", 16'h1);
        exp_push("oor_ack_addr", 16'h0);
`ifdef I2C_IDX_NACK_EN
        exp_push("oor_ack_idx", 16'h1);
        exp_push("oor_ack_d0", 16'h1);
`else
        exp_push("oor_ack_idx", 16'h0);
        exp_push("oor_ack_d0", 16'h0);
        exp_wr.push_back({8'h00, 8'h5A});
`endif
        exp_push("oor_busy_stop", 16'h0);
        bus_write(7'h50, 8'h20, 1, 8'h5A, 8'h00);
`ifdef I2C_IDX_NACK_EN
        host_chk("oor_reg0", 4'd0, 8'h00);
`else
        host_chk("oor_reg0", 4'd0, 8'h5A);
`endif
        host_chk("oor_reg1", 4'd1, 8'h77);

        repeat (10) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL exp_drained got=%0d want=0", exp_q.size());
        end
        total++;
        if (exp_wr.size() != 0) begin
            bad++;
            $display("FAIL wr_drained got=%0d want=0", exp_wr.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
